// File: rtl/reset_seq_monitor.sv
// reset_seq_monitor: checks staggered reset strobes against a mirrored controller counter.
module reset_seq_monitor #(
  parameter int CW   = 8,
  parameter int OFF0 = 2,
  parameter int OFF1 = 5,
  parameter int OFF2 = 7,
  parameter int OFF3 = 9
) (
  input  logic          clk,
  input  logic          por_n,
  input  logic          reset0,
  input  logic          reset1,
  input  logic          reset2,
  input  logic          reset3,
  input  logic          err_clr,
  output logic          seq_done,
  output logic [7:0]    seq_cnt,
  output logic [2:0]    phase,
  output logic          seq_err,
  output logic [3:0]    err_code,
  output logic [CW-1:0] err_at
);
  typedef enum logic [2:0] {IDLE = 3'd0, S0 = 3'd1, S1 = 3'd2, S2 = 3'd3, ERR = 3'd4} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] m_q, at_q, at_d;
  logic          done_q, done_d, err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    code_q, code_d, expv, mm;
  logic          adv;
  assign expv = {m_q == CW'(OFF3), m_q == CW'(OFF2), m_q == CW'(OFF1), m_q == CW'(OFF0)};
  assign mm   = {reset3, reset2, reset1, reset0} ^ expv;
  // Tracking states IDLE..S2 encode the index of the strobe they are waiting for.
  assign adv  = ~|mm && state_q != ERR && expv[state_q[1:0]];
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    code_d  = code_q;
    at_d    = at_q;
    if (|mm) begin
      state_d = ERR;
      if (!err_q || err_clr) begin
        err_d  = 1'b1;
        code_d = mm;
        at_d   = m_q;
      end
    end else begin
      if (err_clr) begin
        err_d  = 1'b0;
        code_d = '0;
        at_d   = '0;
      end
      if (state_q == ERR) state_d = err_clr ? IDLE : ERR;
      else if (adv) begin
        state_d = state_q == S2 ? IDLE : state_t'(state_q + 3'd1);
        done_d  = state_q == S2;
        cnt_d   = state_q == S2 ? cnt_q + {7'd0, cnt_q != 8'hFF} : cnt_q;
      end
    end
  end
  always_ff @(posedge clk or negedge por_n) begin
    if (!por_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      at_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_q + 1'b1;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
      at_q    <= at_d;
    end
  end
  assign seq_done = done_q;
  assign seq_cnt  = cnt_q;
  assign phase    = state_q;
  assign seq_err  = err_q;
  assign err_code = code_q;
  assign err_at   = at_q;
endmodule

// File: tb/tb_reset_seq_monitor.sv
// tb_reset_seq_monitor: scoreboard bench; a period-level model predicts every output snapshot.
module tb_reset_seq_monitor;
  typedef struct packed {
    logic       done;
    logic [7:0] cnt;
    logic [2:0] ph;
    logic       err;
    logic [3:0] code;
    logic [7:0] at;
  } snap_t;
  logic       clk = 1'b0, por = 1'b1, err_clr = 1'b0;
  logic [3:0] rs = 4'd0;
  logic       seq_done, seq_err;
  logic [7:0] seq_cnt, err_at;
  logic [2:0] phase;
  logic [3:0] err_code;
  snap_t      q[$];
  snap_t      exp_s, act_s;
  int         checks = 0, errors = 0;
  int         offs[4] = '{2, 5, 7, 9};
  int         mcnt, prog, m_scnt;
  logic       m_err, m_done;
  logic [3:0] m_code;
  logic [7:0] m_at;
  always #15 clk = ~clk;
  reset_seq_monitor dut (
    .clk(clk), .por_n(~por),
    .reset0(rs[0]), .reset1(rs[1]), .reset2(rs[2]), .reset3(rs[3]),
    .err_clr(err_clr),
    .seq_done(seq_done), .seq_cnt(seq_cnt), .phase(phase),
    .seq_err(seq_err), .err_code(err_code), .err_at(err_at)
  );
  function automatic logic [3:0] ideal(int m);
    return {m == 9, m == 7, m == 5, m == 2};
  endfunction
  function automatic snap_t snap();
    return {m_done, m_scnt[7:0], m_err ? 3'd4 : prog[2:0], m_err, m_code, m_at};
  endfunction
  task automatic model_reset();
    mcnt = 0; prog = 0; m_scnt = 0; m_err = 1'b0; m_done = 1'b0; m_code = '0; m_at = '0;
  endtask
  // prog = how many strobes of the current period were seen correctly in order.
  task automatic model_step(input logic [3:0] r, input logic clr);
    logic [3:0] mm;
    mm = r ^ ideal(mcnt);
    m_done = 1'b0;
    if (mm != 0) begin
      if (!m_err || clr) begin
        m_err = 1'b1; m_code = mm; m_at = mcnt[7:0];
      end
      prog = 0;
    end else begin
      if (!m_err && mcnt == offs[prog]) begin
        if (prog == 3) begin
          prog = 0; m_done = 1'b1;
          if (m_scnt < 255) m_scnt++;
        end else prog++;
      end
      if (clr) begin
        if (m_err) prog = 0;
        m_err = 1'b0; m_code = '0; m_at = '0;
      end
    end
    mcnt = (mcnt + 1) % 256;
  endtask
  task automatic cyc(input logic [3:0] flip, input logic clr, input logic p);
    @(negedge clk);
    #2;
    por = p;
    rs = (p ? 4'd0 : ideal(mcnt)) ^ flip;
    err_clr = clr;
    @(posedge clk);
    if (por) model_reset();
    else model_step(rs, clr);
    q.push_back(snap());
  endtask
  task automatic run(input int n);
    repeat (n) cyc(4'd0, 1'b0, 1'b0);
  endtask
  task automatic run_to(input int t);
    int n = 0;
    while (mcnt != t && n < 600) begin
      cyc(4'd0, 1'b0, 1'b0);
      n++;
    end
  endtask
  task automatic drop_por();
    @(negedge clk);
    #2;
    model_reset();
    q.push_back(snap());
    por = 1'b1;
  endtask
  initial begin
    forever begin
      @(negedge clk or posedge por);
      #1;
      if (q.size() > 0) begin
        exp_s = q.pop_front();
        act_s = {seq_done, seq_cnt, phase, seq_err, err_code, err_at};
        checks++;
        if (act_s !== exp_s) begin
          errors++;
          $display("FAIL snapshot t=%0t got done=%b cnt=%0d phase=%0d err=%b code=%b at=%0d want done=%b cnt=%0d phase=%0d err=%b code=%b at=%0d",
                   $time, act_s.done, act_s.cnt, act_s.ph, act_s.err, act_s.code, act_s.at,
                   exp_s.done, exp_s.cnt, exp_s.ph, exp_s.err, exp_s.code, exp_s.at);
        end
      end
    end
  end
  initial begin
    model_reset();
    cyc(4'd0, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b1);
    run(300);
    run_to(7);
    cyc(4'b0100, 1'b0, 1'b0);
    run_to(20);
    cyc(4'd0, 1'b1, 1'b0);
    run(300);
    run_to(3);
    cyc(4'b0001, 1'b0, 1'b0);
    run_to(30);
    cyc(4'b1000, 1'b1, 1'b0);
    run_to(40);
    cyc(4'd0, 1'b1, 1'b0);
    run_to(0);
    run_to(6);
    drop_por();
    cyc(4'd0, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b1);
    run(300);
    repeat (3000)
      cyc(($urandom_range(0, 149) == 0) ? 4'($urandom) : 4'd0, $urandom_range(0, 99) == 0, 1'b0);
    repeat (3) @(negedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d snapshots left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reset_seq_monitor.md
Name: reset_seq_monitor

Overview:
- Receiving end of the staggered power-on reset strobe interface driven by the mctrl-style reset controller.
- Mirrors the controller's free-running counter and checks each cycle that reset0..reset3 fire exactly at their decided offsets, each for exactly one cycle.
- Reports a per-period completion pulse, a saturating count of good sequences, and a sticky error with diagnostic capture.
- Sits beside the controller in the bench and in the system; both are released from the same power-on event.

Parameters:
- CW, 8: mirror counter width; must equal the controller counter width. Period is 2^CW cycles.
- OFF0, 2: expected count at which reset0 is high.
- OFF1, 5: expected count at which reset1 is high.
- OFF2, 7: expected count at which reset2 is high (OFF0+OFF1).
- OFF3, 9: expected count at which reset3 is high (OFF0+OFF1+2).
- Legal values: OFF0 < OFF1 < OFF2 < OFF3 < 2^CW. Otherwise behaviour is undefined.

Ports:
- clk, input, 1: single clock; same clock as the controller.
- por_n, input, 1: asynchronous, active-low power-on reset. Bench drives it as ~por.
- reset0, input, 1: strobe from controller, expected at OFF0.
- reset1, input, 1: strobe, expected at OFF1.
- reset2, input, 1: strobe, expected at OFF2.
- reset3, input, 1: strobe, expected at OFF3.
- err_clr, input, 1: synchronous clear of the error state.
- seq_done, output, 1: one-cycle pulse after a fully correct sequence.
- seq_cnt, output, 8: number of correct sequences, saturating at 255.
- phase, output, 3: FSM state encoding.
- seq_err, output, 1: sticky error flag.
- err_code, output, 4: bitmask of strobes that mismatched at the first error.
- err_at, output, CW: mirror count at the first error.

Behaviour:
- Reset (por_n=0, async): mirror=0, phase=IDLE, seq_done=0, seq_cnt=0, seq_err=0, err_code=0, err_at=0. All outputs hold while por_n=0.
- Mirror counter: increments by 1 on every posedge clk while por_n=1 and wraps 2^CW-1 -> 0. It tracks the controller count exactly: both are 0 after power-on reset.
- Check rule, evaluated at every posedge using the pre-increment mirror value m:
  - expected_i = (m == OFFi) for i = 0..3.
  - mismatch_i = reset_i XOR expected_i.
  - This catches missing, early, late, stretched and spurious pulses.
- First error: if any mismatch_i=1 and seq_err=0, then next cycle seq_err=1, err_code=mismatch vector {3..0}, err_at=m. Later mismatches do not update the capture.
- err_clr=1 at a posedge: clears seq_err, err_code and err_at. If a mismatch occurs on the same edge, that new error is captured instead (error wins).
- FSM states and encoding: IDLE=0, S0=1, S1=2, S2=3, ERR=4.
  - IDLE -> S0 on a correct reset0 at m=OFF0.
  - S0 -> S1 on a correct reset1 at OFF1.
  - S1 -> S2 on a correct reset2 at OFF2.
  - S2 -> IDLE on a correct reset3 at OFF3; this edge also raises seq_done for one cycle and increments seq_cnt.
  - Any mismatch in any state -> ERR.
  - ERR -> IDLE only on err_clr. From there, tracking resumes at the next period's OFF0.
- Latency: seq_done is high in the cycle after the posedge at which m=OFF3, and only if the whole period from OFF0 to OFF3 had no mismatch.
- seq_cnt: increments on each seq_done and holds at 255.
- Wrap: strobes recur every 2^CW cycles. Mirror wrap requires no special handling.
- Reset mid-operation: async clear back to reset values. Any partially observed sequence is discarded.

Test Plan:
- Nominal: clk period 30 ns, por pulse at 10-20 ns, connected to mctrl with 8-bit counter -> seq_err=0 throughout; seq_done pulses once per 256 cycles; seq_cnt=1 after the first period; phase walks 0,1,2,3,0.
- Missing strobe: force reset2=0 when m=7 -> seq_err=1, err_code=4'b0100, err_at=7, phase=4; seq_done never asserts.
- Stretched strobe: hold reset0=1 for m=2..3 -> err_code=4'b0001, err_at=3.
- Error clear: after the missing-strobe error, pulse err_clr at m=20 -> seq_err=0, err_code=0, err_at=0; the next period completes with seq_done=1 and seq_cnt incremented.
- Simultaneous err_clr and mismatch: err_clr=1 on the same edge as a spurious reset3 at m=30 -> seq_err stays 1, err_code=4'b1000, err_at=30.
- Async reset mid-sequence: drop por_n at m=6 (phase=2) -> all outputs 0 immediately. After release together with the controller's por, the full sequence completes cleanly.
